// File: rtl/spi_reg_bridge.sv
// spi_reg_bridge: turns SPI slave frames into register-bus write/read bursts.
// Define SPI_REG_BRIDGE_AUTOINC_EN to advance the address after every data word.
module spi_reg_bridge #(
  parameter int DATA_WDT = 8,
  parameter int ADDR_WDT = 7,
  parameter logic [DATA_WDT-1:0] STATUS_WORD = 'hA5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                spiStart,
  input  logic                spiEnd,
  input  logic                spiTxLoad,
  input  logic                spiRxRdy,
  input  logic [DATA_WDT-1:0] spiRxData,
  output logic [DATA_WDT-1:0] spiTxData,
  output logic [ADDR_WDT-1:0] regAddr,
  output logic                regWr,
  output logic [DATA_WDT-1:0] regWrData,
  output logic                regRd,
  input  logic [DATA_WDT-1:0] regRdData
);
  typedef enum logic [1:0] {IDLE, CMD, WRITE, READ} state_t;
  state_t state, state_n;
  logic [ADDR_WDT-1:0] ptr, ptr_n, adv_ptr, addr_n;
  logic [DATA_WDT-1:0] tx_n, wdata_n;
  logic primed, primed_n, rd_d, wr_n, rd_n;
`ifdef SPI_REG_BRIDGE_AUTOINC_EN
  assign adv_ptr = ptr + ADDR_WDT'(1);
`else
  assign adv_ptr = ptr;
`endif
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      ptr       <= '0;
      primed    <= 1'b0;
      rd_d      <= 1'b0;
      spiTxData <= STATUS_WORD;
      regAddr   <= '0;
      regWr     <= 1'b0;
      regWrData <= '0;
      regRd     <= 1'b0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      primed    <= primed_n;
      rd_d      <= regRd;
      spiTxData <= tx_n;
      regAddr   <= addr_n;
      regWr     <= wr_n;
      regWrData <= wdata_n;
      regRd     <= rd_n;
    end
  end
  always_comb begin
    state_n  = state;
    ptr_n    = ptr;
    primed_n = primed;
    tx_n     = spiTxData;
    addr_n   = regAddr;
    wr_n     = 1'b0;
    wdata_n  = regWrData;
    rd_n     = 1'b0;
    if (spiStart) begin
      state_n  = CMD;
      primed_n = 1'b0;
      tx_n     = STATUS_WORD;
    end else begin
      case (state)
        IDLE: tx_n = STATUS_WORD;
        CMD: begin
          tx_n = STATUS_WORD;
          if (spiRxRdy) begin
            ptr_n    = spiRxData[ADDR_WDT-1:0];
            state_n  = spiRxData[DATA_WDT-1] ? READ : WRITE;
            rd_n     = spiRxData[DATA_WDT-1];
            addr_n   = spiRxData[DATA_WDT-1] ? spiRxData[ADDR_WDT-1:0] : regAddr;
            primed_n = 1'b0;
          end
        end
        WRITE: begin
          tx_n = STATUS_WORD;
          if (spiRxRdy) begin
            wr_n    = 1'b1;
            addr_n  = ptr;
            wdata_n = spiRxData;
            ptr_n   = adv_ptr;
          end
        end
        default: begin
          if (rd_d) begin
            tx_n     = regRdData;
            primed_n = 1'b1;
          end
          // a load racing the frame end would only prefetch a word nobody reads
          if (spiTxLoad && primed && !spiEnd) begin
            ptr_n    = adv_ptr;
            rd_n     = 1'b1;
            addr_n   = adv_ptr;
            primed_n = 1'b0;
          end
        end
      endcase
      if (spiEnd) begin
        state_n  = IDLE;
        primed_n = 1'b0;
        tx_n     = STATUS_WORD;
      end
    end
  end
endmodule

// File: tb/tb_spi_reg_bridge.sv
// tb_spi_reg_bridge: directed frames against a transaction-level model of the bridge.
module tb_spi_reg_bridge;
  localparam logic [7:0] ST = 8'hA5;
`ifdef SPI_REG_BRIDGE_AUTOINC_EN
  localparam int STEP = 1;
`else
  localparam int STEP = 0;
`endif
  logic clk = 1'b0, reset = 1'b0, init = 1'b1;
  logic spiStart = 1'b0, spiEnd = 1'b0, spiTxLoad = 1'b0, spiRxRdy = 1'b0;
  logic [7:0] spiRxData = '0, spiTxData, regWrData, regRdData;
  logic [6:0] regAddr;
  logic regWr, regRd;
  logic [7:0] mem [128];
  logic [7:0] ref_mem [128];
  logic [7:0] fw [$];
  logic [14:0] exp_wr [$];
  logic [6:0] exp_rd [$];
  logic [7:0] exp_miso [$];
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  spi_reg_bridge dut (
    .clk(clk), .reset(reset), .spiStart(spiStart), .spiEnd(spiEnd),
    .spiTxLoad(spiTxLoad), .spiRxRdy(spiRxRdy), .spiRxData(spiRxData),
    .spiTxData(spiTxData), .regAddr(regAddr), .regWr(regWr),
    .regWrData(regWrData), .regRd(regRd), .regRdData(regRdData)
  );

  always @(posedge clk) begin
    if (init) begin
      for (int i = 0; i < 128; i++) mem[i] <= 8'(i - 15);
      regRdData <= '0;
    end else begin
      if (regRd) regRdData <= mem[regAddr];
      if (regWr) mem[regAddr] <= regWrData;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset && !init) begin
      chk("wr_rd_exclusive", {31'd0, regWr & regRd}, 0);
      if (regWr) begin
        if (exp_wr.size() == 0) chk("unexpected_wr", {25'd0, regAddr}, 32'hFFFF);
        else chk("wr_addr_data", {17'd0, regAddr, regWrData}, {17'd0, exp_wr.pop_front()});
      end
      if (regRd) begin
        if (exp_rd.size() == 0) chk("unexpected_rd", {25'd0, regAddr}, 32'hFFFF);
        else chk("rd_addr", {25'd0, regAddr}, {25'd0, exp_rd.pop_front()});
      end
    end
  end

  task automatic model(input int n, input bit e);
    logic rd;
    logic [6:0] a, ad;
    int nr;
    rd = fw[0][7];
    a = fw[0][6:0];
    exp_miso.delete();
    for (int k = 0; k <= n; k++)
      exp_miso.push_back((rd && k >= 2) ? ref_mem[7'(int'(a) + (k - 2) * STEP)] : ST);
    if (!rd) begin
      for (int k = 1; k < n; k++) begin
        ad = 7'(int'(a) + (k - 1) * STEP);
        exp_wr.push_back({ad, fw[k]});
        ref_mem[ad] = fw[k];
      end
    end else begin
      nr = 1 + ((n - 1 - int'(e)) > 0 ? (n - 1 - int'(e)) : 0);
      for (int j = 0; j < nr; j++) exp_rd.push_back(7'(int'(a) + j * STEP));
    end
  endtask

  task automatic frame(input int n, input bit e);
    model(n, e);
    spiStart = 1'b1;
    @(negedge clk);
    spiStart = 1'b0;
    repeat (3) @(negedge clk);
    chk("miso_word0", {24'd0, spiTxData}, {24'd0, ST});
    for (int i = 0; i < n; i++) begin
      spiRxData = fw[i];
      spiRxRdy = 1'b1;
      spiTxLoad = 1'b1;
      spiEnd = e && (i == n - 1);
      if (!spiEnd) chk($sformatf("miso_word%0d", i + 1), {24'd0, spiTxData}, {24'd0, exp_miso[i + 1]});
      @(negedge clk);
      spiRxRdy = 1'b0;
      spiTxLoad = 1'b0;
      spiEnd = 1'b0;
      chk("wr_latency", {31'd0, regWr}, {31'd0, !fw[0][7] && i > 0});
      repeat (4) @(negedge clk);
    end
    repeat (3) @(negedge clk);
    chk("wr_drained", exp_wr.size(), 0);
    chk("rd_drained", exp_rd.size(), 0);
    if (e) chk("idle_status", {24'd0, spiTxData}, {24'd0, ST});
  endtask

  task automatic chk_reset_vals();
    chk("rst_txdata", {24'd0, spiTxData}, {24'd0, ST});
    chk("rst_addr", {25'd0, regAddr}, 0);
    chk("rst_wr", {31'd0, regWr}, 0);
    chk("rst_wdata", {24'd0, regWrData}, 0);
    chk("rst_rd", {31'd0, regRd}, 0);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) ref_mem[i] = 8'(i - 15);
    repeat (3) @(negedge clk);
    chk_reset_vals();
    init = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    fw = '{8'h05, 8'h11, 8'h22, 8'h33};
    frame(4, 1);
    chk("pin_write_burst", {24'd0, mem[STEP != 0 ? 7 : 5]}, 32'h33);
    fw = '{8'h90, 8'h00, 8'h00, 8'h00, 8'h00};
    frame(5, 1);
    chk("pin_read_word4", {24'd0, exp_miso[4]}, STEP != 0 ? 32'h03 : 32'h01);
    fw = '{8'h7F, 8'hAA, 8'hBB};
    frame(3, 1);
    chk("pin_wrap_lo", {24'd0, mem[0]}, STEP != 0 ? 32'hBB : 32'hF1);
    chk("pin_wrap_hi", {24'd0, mem[127]}, STEP != 0 ? 32'hAA : 32'hBB);
    fw = '{8'h03, 8'h01, 8'h02};
    frame(3, 1);
    chk("pin_fifo_wr", {24'd0, mem[3]}, STEP != 0 ? 32'h01 : 32'h02);
    fw = '{8'h83, 8'h00, 8'h00, 8'h00};
    frame(4, 1);
    chk("pin_fifo_rd", {24'd0, exp_miso[2]}, STEP != 0 ? 32'h01 : 32'h02);
    fw = '{8'h85};
    frame(1, 1);
    fw = '{8'h90, 8'h00};
    frame(2, 0);
    reset = 1'b0;
    #1;
    chk_reset_vals();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    fw = '{8'h02, 8'h44};
    frame(2, 1);
    chk("pin_after_abort", {24'd0, mem[2]}, 32'h44);
    fw = '{8'h20, 8'h66};
    frame(2, 0);
    fw = '{8'h01, 8'h55};
    frame(2, 1);
    chk("pin_restart", {24'd0, mem[1]}, 32'h55);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout actual=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
